// File: rtl/rx_pkg.sv
// Shared types and default constants for the rx_deser serial receiver.
package rx_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

   localparam int unsigned RxWidthDefault      = 8;
   localparam int unsigned RxClksPerBitDefault = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{ResetVal}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/rx_deser.sv
// Serial frame receiver (start, WIDTH data bits MSB first, stop) with mid-bit sampling.
// Define RX_FRAME_ERR_EN to get a one-cycle rx_frame_err pulse on a bad stop bit.
module rx_deser
   import rx_pkg::*;
#(
   parameter int unsigned WIDTH        = RxWidthDefault,
   parameter int unsigned CLKS_PER_BIT = RxClksPerBitDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_si,
   output logic [WIDTH-1:0] rx_po,
   output logic             rx_valid,
   output logic             rx_busy,
   output logic             rx_frame_err
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CntW-1:0] CntBitEnd = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf   = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(WIDTH - 1);

   logic             rx_s;
   rx_state_e        state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] po_q, po_d;
   logic             valid_q, valid_d;
   logic             stop_done;

   sync_2ff #(
      .ResetVal (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx_si),
      .q_o (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         po_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         po_q    <= po_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // A start bit that is high again at its midpoint is treated as a glitch.
            if (cnt_q == CntHalf) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d   = '0;
               shift_d = (shift_q << 1) | WIDTH'(rx_s);
               idx_d   = idx_q + IdxW'(1);
               if (idx_q == IdxLast) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stop_done = (state_q == STOP) && (cnt_q == CntBitEnd);
      valid_d   = stop_done && rx_s;
      po_d      = valid_d ? shift_q : po_q;
      rx_busy   = (state_q != IDLE);
   end

   assign rx_po    = po_q;
   assign rx_valid = valid_q;

`ifdef RX_FRAME_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= stop_done && !rx_s;
      end
   end

   assign rx_frame_err = err_q;
`else
   assign rx_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deser.sv
// Bench for rx_deser: three instances (16, 2 and 255 clocks per bit) against a frame-level model.
module tb_rx_deser;

   localparam int NDUT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line   [NDUT];
   logic [7:0] po        [NDUT];
   logic       valid     [NDUT];
   logic       busy      [NDUT];
   logic       ferr      [NDUT];

   rx_deser #(.WIDTH(8), .CLKS_PER_BIT(16)) u_dut16 (
      .clk (clk), .rst (rst), .rx_si (rx_line[0]), .rx_po (po[0]),
      .rx_valid (valid[0]), .rx_busy (busy[0]), .rx_frame_err (ferr[0])
   );
   rx_deser #(.WIDTH(8), .CLKS_PER_BIT(2)) u_dut2 (
      .clk (clk), .rst (rst), .rx_si (rx_line[1]), .rx_po (po[1]),
      .rx_valid (valid[1]), .rx_busy (busy[1]), .rx_frame_err (ferr[1])
   );
   rx_deser #(.WIDTH(8), .CLKS_PER_BIT(255)) u_dut255 (
      .clk (clk), .rst (rst), .rx_si (rx_line[2]), .rx_po (po[2]),
      .rx_valid (valid[2]), .rx_busy (busy[2]), .rx_frame_err (ferr[2])
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         valid_cnt [NDUT] = '{0, 0, 0};
   int         err_cnt   [NDUT] = '{0, 0, 0};
   int         busy_cnt  [NDUT] = '{0, 0, 0};
   int         valid_cyc [NDUT] = '{0, 0, 0};
   int         start_cyc [NDUT] = '{0, 0, 0};
   logic [7:0] po_log0 [$];

   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (valid[k] === 1'b1) begin
            valid_cnt[k] <= valid_cnt[k] + 1;
            valid_cyc[k] <= cyc;
            if (k == 0) po_log0.push_back(po[k]);
         end
         if (ferr[k] === 1'b1) err_cnt[k] <= err_cnt[k] + 1;
         if (busy[k] === 1'b1) busy_cnt[k] <= busy_cnt[k] + 1;
      end
   end

   // Frame-level reference: last good word, number of good frames, number of bad-stop frames.
   logic [7:0] exp_po  [NDUT] = '{8'h00, 8'h00, 8'h00};
   int         exp_cnt [NDUT] = '{0, 0, 0};
   int         exp_err [NDUT] = '{0, 0, 0};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cpb_of(input int k);
      case (k)
         0:       return 16;
         1:       return 2;
         default: return 255;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all(input int k, input string tag);
      check($sformatf("%s_po_dut%0d", tag, k), po[k], exp_po[k]);
      check($sformatf("%s_nvalid_dut%0d", tag, k), valid_cnt[k], exp_cnt[k]);
      check($sformatf("%s_nferr_dut%0d", tag, k), err_cnt[k], exp_err[k]);
   endtask

   // Serialise one frame; rst_bit >= 0 pulses rst mid-way through that data bit and abandons it.
   task automatic send(input int k, input logic [7:0] d, input logic stop_b,
                       input int rst_bit, input bit chk_busy);
      logic [9:0] bits;
      int         c;
      c       = cpb_of(k);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[7-i];
      bits[9] = stop_b;
      @(negedge clk);
      start_cyc[k] = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_line[k] = bits[i];
         for (int j = 0; j < c; j++) begin
            @(negedge clk);
            if (j == c / 2) begin
               if (chk_busy) check($sformatf("busy_bit%0d", i), busy[k], 1);
               if (rst_bit >= 0 && i == rst_bit + 1) begin
                  rst        = 1'b1;
                  rx_line[k] = 1'b1;
                  @(negedge clk);
                  rst = 1'b0;
                  for (int m = 0; m < NDUT; m++) exp_po[m] = 8'h00;
                  return;
               end
            end
         end
      end
      rx_line[k] = 1'b1;
      if (stop_b) begin
         exp_cnt[k]++;
         exp_po[k] = d;
      end else begin
`ifdef RX_FRAME_ERR_EN
         exp_err[k]++;
`endif
      end
   endtask

   initial begin
      int base;
      int bsy0;
      int lat;
      int k;
      logic [7:0] d;
      logic st;

      for (int m = 0; m < NDUT; m++) rx_line[m] = 1'b1;
      rst = 1'b1;
      idle(5);
      rst = 1'b0;
      idle(3);

      // Reset state
      check("rst_po", po[0], 8'h00);
      check("rst_valid", valid[0], 1'b0);
      check("rst_busy", busy[0], 1'b0);
      check("rst_ferr", ferr[0], 1'b0);
      check("rst_po_dut2", po[1], 8'h00);
      check("rst_po_dut255", po[2], 8'h00);

      // Single 0xA5 frame with latency and busy coverage
      send(0, 8'hA5, 1'b1, -1, 1'b1);
      idle(2 * 16 + 5);
      check_all(0, "a5");
      lat = valid_cyc[0] - start_cyc[0];
      check("a5_latency_152_157", (lat >= 152 && lat <= 157), 1'b1);
      check("a5_busy_after", busy[0], 1'b0);

      // Back-to-back 0x00 then 0xFF
      base = po_log0.size();
      send(0, 8'h00, 1'b1, -1, 1'b0);
      send(0, 8'hFF, 1'b1, -1, 1'b0);
      idle(2 * 16 + 5);
      check("b2b_count", po_log0.size() - base, 2);
      if (po_log0.size() >= base + 2) begin
         check("b2b_first", po_log0[base], 8'h00);
         check("b2b_second", po_log0[base+1], 8'hFF);
      end
      check_all(0, "b2b");

      // Four-cycle glitch on idle line
      bsy0 = busy_cnt[0];
      @(negedge clk);
      rx_line[0] = 1'b0;
      idle(4);
      rx_line[0] = 1'b1;
      idle(40);
      check("glitch_busy_1_10", (busy_cnt[0] - bsy0 >= 1 && busy_cnt[0] - bsy0 <= 10), 1'b1);
      check("glitch_busy_now", busy[0], 1'b0);
      check_all(0, "glitch");

      // Bad stop bit
      send(0, 8'h3C, 1'b0, -1, 1'b0);
      idle(2 * 16 + 5);
      check_all(0, "badstop");

      // Reset during data bit 4 of 0x81, then a clean 0x81
      send(0, 8'h81, 1'b1, 4, 1'b0);
      check("midrst_po", po[0], 8'h00);
      check("midrst_valid", valid[0], 1'b0);
      check("midrst_busy", busy[0], 1'b0);
      check("midrst_ferr", ferr[0], 1'b0);
      idle(200);
      check_all(0, "midrst_quiet");
      send(0, 8'h81, 1'b1, -1, 1'b0);
      idle(2 * 16 + 5);
      check_all(0, "after_rst");

      // Extreme bit periods
      send(1, 8'hA5, 1'b1, -1, 1'b0);
      idle(2 * 2 + 5);
      check_all(1, "a5_cpb2");
      send(2, 8'hA5, 1'b1, -1, 1'b0);
      idle(2 * 255 + 5);
      check_all(2, "a5_cpb255");

      // Random frames across the three instances
      for (int n = 0; n < 15; n++) begin
         k  = ($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(0, 1));
         d  = 8'($urandom);
         st = ($urandom_range(0, 3) != 0);
         send(k, d, st, -1, 1'b0);
         idle(2 * cpb_of(k) + 5 + int'($urandom_range(0, 20)));
         check_all(k, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
